// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 16-bit datapath ALU.
// Each instruction walks FETCH -> WAIT -> DECODE -> EXEC. The write strobes
// are decoded from the current state, so an asynchronous reset drops them at once.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   FETCH  | instr_rd high, pc presented to program memory
//   WAIT   | memory latency cycle
//   DECODE | ir captured from instr
//   EXEC   | write strobes for one cycle, zf and pc updated
//   HALT   | done high, pc frozen, waiting for start
module control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     instr,
    input  logic [1:0]      z,
    output logic [PC_W-1:0] pc,
    output logic            instr_rd,
    output logic [2:0]      alu_op,
    output logic            in1_sel,
    output logic            in2_sel,
    output logic [7:0]      imm,
    output logic [3:0]      rf_addr,
    output logic            rf_we,
    output logic            ac_we,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_STR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] target;
    logic [15:0]     ir;
    logic            zf;
    logic [3:0]      opcode;
    logic            wr_ac;
    logic            wr_rf;
    logic            set_flag;

    // Only z[0] carries the zero flag; z[1] is deliberately ignored.
    logic unused_z;
    assign unused_z = z[1];

    assign opcode  = ir[15:12];
    assign rf_addr = ir[11:8];
    assign imm     = ir[7:0];
    assign target  = PC_W'(ir[7:0]);

    // Sequencer registers: state, program counter, instruction and zero flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            zf    <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_DECODE)
                ir <= instr;
            if (state == S_EXEC && set_flag)
                zf <= z[0];
        end
    end

    // Datapath controls decoded from ir in every state; undefined opcodes act as NOP.
    always_comb begin
        alu_op   = 3'd0;
        in1_sel  = 1'b0;
        in2_sel  = 1'b0;
        wr_ac    = 1'b0;
        wr_rf    = 1'b0;
        set_flag = 1'b0;
        case (opcode)
            OP_ADD: begin alu_op = 3'd0; wr_ac = 1'b1; set_flag = 1'b1; end
            OP_SUB: begin alu_op = 3'd1; wr_ac = 1'b1; set_flag = 1'b1; end
            OP_MUL: begin alu_op = 3'd2; wr_ac = 1'b1; set_flag = 1'b1; end
            OP_STR: begin alu_op = 3'd4; wr_rf = 1'b1; end
            OP_LDI: begin alu_op = 3'd4; in2_sel = 1'b1; wr_ac = 1'b1; end
            OP_DEC: begin alu_op = 3'd1; in1_sel = 1'b1; wr_ac = 1'b1; set_flag = 1'b1; end
            default: ;
        endcase
    end

    // Next-state, next-pc and the per-state strobes.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_rd  = 1'b0;
        done      = 1'b0;
        rf_we     = 1'b0;
        ac_we     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                instr_rd  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:   state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                ac_we  = wr_ac;
                rf_we  = wr_rf;
                pc_nxt = pc + PC_W'(1);
                if (opcode == OP_JMP || (opcode == OP_JZ && zf))
                    pc_nxt = target;
                state_nxt = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
